// File: rtl/bit_splitter_param_if.sv
// Handshake bundle for the serial-to-parallel symbol splitter.
// Master drives bits and sym_ready; slave returns symbols and status.
interface bit_splitter_param_if #(
    parameter int BITS_PER_SYM = 2,
    parameter int CNT_W        = 16
);
    logic                    data;
    logic                    data_valid;
    logic                    sof;
    logic                    data_ready;
    logic [BITS_PER_SYM-1:0] sym_out;
    logic                    sym_valid;
    logic                    sym_ready;
    logic                    sync_err;
    logic [CNT_W-1:0]        sym_count;

    modport master (
        output data, data_valid, sof, sym_ready,
        input  data_ready, sym_out, sym_valid, sync_err, sym_count
    );

    modport slave (
        input  data, data_valid, sof, sym_ready,
        output data_ready, sym_out, sym_valid, sync_err, sym_count
    );
endinterface

// File: rtl/bit_splitter_param.sv
// Packs a serial bit stream into BITS_PER_SYM-bit symbols with sof
// realignment, a one-entry output register and a consumed-symbol counter.
module bit_splitter_param #(
    parameter int BITS_PER_SYM = 2,
    parameter bit MSB_FIRST    = 1'b1,
    parameter int CNT_W        = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    bit_splitter_param_if.slave   bus
);
    localparam int CW = (BITS_PER_SYM > 2) ? $clog2(BITS_PER_SYM) : 1;
    localparam logic [CW-1:0] LAST = CW'(BITS_PER_SYM - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BITS_PER_SYM-1:0] shreg_q, shreg_d;
    logic [BITS_PER_SYM-1:0] sym_q, sym_d;
    logic                    sym_valid_q, sym_valid_d;
    logic                    sync_err_q, sync_err_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic                    data_ready;
    logic                    accept;
    logic                    consume;
    logic [CW-1:0]           k;
    logic [CW-1:0]           pos;
    logic [BITS_PER_SYM-1:0] packed_bits;

    // Stall only when this bit would complete a symbol into a full, stuck register
    assign data_ready = rst_n
                     && ((cnt_q != LAST) || !sym_valid_q || bus.sym_ready);

    always_comb begin
        accept      = bus.data_valid && data_ready;
        consume     = sym_valid_q && bus.sym_ready;
        k           = bus.sof ? '0 : cnt_q;
        pos         = MSB_FIRST ? (LAST - k) : k;
        packed_bits = bus.sof ? '0 : shreg_q;
        for (int i = 0; i < BITS_PER_SYM; i++) begin
            if (pos == CW'(i)) begin
                packed_bits[i] = bus.data;
            end
        end

        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        sym_d       = sym_q;
        sym_valid_d = sym_valid_q && !consume;
        sync_err_d  = 1'b0;
        count_d     = consume ? count_q + CNT_W'(1) : count_q;

        if (accept) begin
            sync_err_d = bus.sof && (cnt_q != '0);
            if (k == LAST) begin
                cnt_d       = '0;
                shreg_d     = '0;
                sym_d       = packed_bits;
                sym_valid_d = 1'b1;
            end else begin
                cnt_d   = k + CW'(1);
                shreg_d = packed_bits;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            shreg_q     <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            sync_err_q  <= sync_err_d;
            count_q     <= count_d;
        end
    end

    assign bus.data_ready = data_ready;
    assign bus.sym_out    = sym_q;
    assign bus.sym_valid  = sym_valid_q;
    assign bus.sync_err   = sync_err_q;
    assign bus.sym_count  = count_q;
endmodule

// File: tb/tb_bit_splitter_param.sv
// Scoreboard bench: three splitter configurations, expected symbols
// queued at stimulus time and compared when the DUT hands them off.
module tb_bit_splitter_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    bit_splitter_param_if #(.BITS_PER_SYM(2), .CNT_W(16)) a_if ();
    bit_splitter_param_if #(.BITS_PER_SYM(2), .CNT_W(16)) b_if ();
    bit_splitter_param_if #(.BITS_PER_SYM(4), .CNT_W(4))  c_if ();

    bit_splitter_param #(.BITS_PER_SYM(2), .MSB_FIRST(1'b1), .CNT_W(16))
        u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    bit_splitter_param #(.BITS_PER_SYM(2), .MSB_FIRST(1'b0), .CNT_W(16))
        u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
    bit_splitter_param #(.BITS_PER_SYM(4), .MSB_FIRST(1'b1), .CNT_W(4))
        u_c (.clk(clk), .rst_n(rst_n), .bus(c_if.slave));

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] qc[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        cyc();
    endtask

    always @(negedge clk) begin
        if (rst_n && a_if.sym_valid && a_if.sym_ready) begin
            if (qa.size() == 0) chk("a_extra", 32'(qa.size()), 1);
            else chk("a_sym", 32'(a_if.sym_out), 32'(qa.pop_front()));
        end
        if (rst_n && b_if.sym_valid && b_if.sym_ready) begin
            if (qb.size() == 0) chk("b_extra", 32'(qb.size()), 1);
            else chk("b_sym", 32'(b_if.sym_out), 32'(qb.pop_front()));
        end
        if (rst_n && c_if.sym_valid && c_if.sym_ready) begin
            if (qc.size() == 0) chk("c_extra", 32'(qc.size()), 1);
            else chk("c_sym", 32'(c_if.sym_out), 32'(qc.pop_front()));
        end
    end

    initial begin
        logic [3:0] bits;
        logic [5:0] dat;
        logic [5:0] sf;
        logic [7:0] sym;
        logic       b;

        a_if.data = 0; a_if.data_valid = 0; a_if.sof = 0; a_if.sym_ready = 0;
        b_if.data = 0; b_if.data_valid = 0; b_if.sof = 0; b_if.sym_ready = 0;
        c_if.data = 0; c_if.data_valid = 0; c_if.sof = 0; c_if.sym_ready = 0;

        #1;
        chk("rst_rdy", 32'(c_if.data_ready), 0);
        chk("rst_vld", 32'(c_if.sym_valid), 0);
        chk("rst_out", 32'(c_if.sym_out), 0);
        chk("rst_err", 32'(c_if.sync_err), 0);
        chk("rst_cnt", 32'(c_if.sym_count), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        cyc();
        chk("rel_rdy", 32'(a_if.data_ready), 1);

        // bit order: same stream into MSB-first and LSB-first
        bits = 4'b1011;
        a_if.sym_ready = 1; b_if.sym_ready = 1;
        qa.push_back(8'h2); qa.push_back(8'h3);
        qb.push_back(8'h1); qb.push_back(8'h3);
        for (int i = 0; i < 4; i++) begin
            a_if.data = bits[3-i]; a_if.data_valid = 1;
            b_if.data = bits[3-i]; b_if.data_valid = 1;
            chk("t1_rdy", 32'(a_if.data_ready), 1);
            chk("t2_rdy", 32'(b_if.data_ready), 1);
            cyc();
            chk("t1_vld", 32'(a_if.sym_valid), 32'(i % 2));
            chk("t2_vld", 32'(b_if.sym_valid), 32'(i % 2));
        end
        a_if.data_valid = 0; b_if.data_valid = 0;
        cyc();
        chk("t1_idle", 32'(a_if.sym_valid), 0);
        chk("t2_idle", 32'(b_if.sym_valid), 0);
        chk("t1_cnt", 32'(a_if.sym_count), 2);

        // backpressure
        do_reset();
        a_if.sym_ready = 0;
        qa.push_back(8'h2); qa.push_back(8'h1);
        bits = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            a_if.data = bits[3-i]; a_if.data_valid = 1;
            chk("t3_rdy", 32'(a_if.data_ready), 1);
            cyc();
        end
        a_if.data = bits[0];
        chk("t3_stall", 32'(a_if.data_ready), 0);
        chk("t3_hold_v", 32'(a_if.sym_valid), 1);
        chk("t3_hold_o", 32'(a_if.sym_out), 2);
        cyc();
        chk("t3_stall2", 32'(a_if.data_ready), 0);
        chk("t3_hold_o2", 32'(a_if.sym_out), 2);
        a_if.sym_ready = 1;
        #1;
        chk("t3_drain_rdy", 32'(a_if.data_ready), 1);
        cyc();
        a_if.sym_ready = 0; a_if.data_valid = 0;
        chk("t3_new_v", 32'(a_if.sym_valid), 1);
        chk("t3_new_o", 32'(a_if.sym_out), 1);
        chk("t3_cnt1", 32'(a_if.sym_count), 1);
        cyc();
        a_if.sym_ready = 1;
        cyc();
        a_if.sym_ready = 0;
        chk("t3_cnt2", 32'(a_if.sym_count), 2);
        chk("t3_empty", 32'(a_if.sym_valid), 0);

        // sof realignment on the 4-bit instance
        c_if.sym_ready = 1;
        dat = 6'b110101;
        sf  = 6'b001000;
        qc.push_back(8'h5);
        for (int i = 0; i < 6; i++) begin
            c_if.data = dat[5-i]; c_if.sof = sf[5-i]; c_if.data_valid = 1;
            cyc();
            chk("t4_err", 32'(c_if.sync_err), 32'(i == 2));
        end
        c_if.data_valid = 0; c_if.sof = 0;
        chk("t4_vld", 32'(c_if.sym_valid), 1);
        chk("t4_out", 32'(c_if.sym_out), 5);
        cyc();
        chk("t4_err_end", 32'(c_if.sync_err), 0);
        chk("t4_cnt", 32'(c_if.sym_count), 1);

        // asynchronous reset mid-symbol
        a_if.sym_ready = 1;
        a_if.data = 1; a_if.data_valid = 1;
        cyc();
        a_if.data_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rdy", 32'(a_if.data_ready), 0);
        chk("t5_vld", 32'(a_if.sym_valid), 0);
        chk("t5_out", 32'(a_if.sym_out), 0);
        chk("t5_cnt", 32'(a_if.sym_count), 0);
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        cyc();
        qa.push_back(8'h1);
        a_if.data = 0; a_if.data_valid = 1;
        cyc();
        a_if.data = 1;
        cyc();
        a_if.data_valid = 0;
        chk("t5_new_v", 32'(a_if.sym_valid), 1);
        chk("t5_new_o", 32'(a_if.sym_out), 1);
        cyc();
        chk("t5_cnt_after", 32'(a_if.sym_count), 1);

        // counter wrap, CNT_W=4
        do_reset();
        c_if.sym_ready = 1;
        for (int j = 1; j <= 17; j++) begin
            sym = 8'h0;
            for (int i = 0; i < 4; i++) begin
                b = 1'($urandom_range(0, 1));
                sym = {sym[6:0], b};
                c_if.data = b; c_if.data_valid = 1;
                cyc();
                if (i == 0 && j >= 2)
                    chk("t6_cnt", 32'(c_if.sym_count), 32'((j - 1) % 16));
            end
            qc.push_back(sym);
        end
        c_if.data_valid = 0;
        cyc();
        chk("t6_wrap", 32'(c_if.sym_count), 1);
        cyc();

        chk("qa_left", 32'(qa.size()), 0);
        chk("qb_left", 32'(qb.size()), 0);
        chk("qc_left", 32'(qc.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bit_splitter_param.md
Name: bit_splitter_param

Overview:
Parametrised serial-to-parallel symbol splitter for the modulator front end. It packs a serial bit stream into BITS_PER_SYM-bit symbols: 2 for QPSK I/Q, 4 for 16-QAM, and so on. Symbols are delivered to the downstream mapper through a valid/ready handshake with a one-entry output register. It adds start-of-frame realignment, selectable bit order, backpressure and a symbol counter.

Parameters:
BITS_PER_SYM, 2, bits per output symbol; legal range 2..8.
MSB_FIRST, 1, 1: first received bit goes to sym_out[BITS_PER_SYM-1]; 0: first received bit goes to sym_out[0].
CNT_W, 16, width of the emitted-symbol counter.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
data  input  1  serial input bit.
data_valid  input  1  data is valid this cycle.
sof  input  1  qualifies data: this bit is bit 0 of a new symbol.
data_ready  output  1  block accepts a bit this cycle.
sym_out  output  BITS_PER_SYM  assembled symbol.
sym_valid  output  1  sym_out holds an unconsumed symbol.
sym_ready  input  1  downstream consumes sym_out this cycle.
sync_err  output  1  one-cycle pulse: partial symbol discarded by sof.
sym_count  output  CNT_W  number of symbols consumed, modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Bit counter cnt=0 and shift register cleared.
  - sym_out=0, sym_valid=0, sync_err=0, sym_count=0.
  - data_ready is forced 0 while rst_n is low.
  - Any partial symbol or held symbol is lost; after release, the next accepted bit is bit 0.
- Bit acceptance:
  - A bit is accepted when data_valid && data_ready.
  - With no accept, cnt and the shift register hold.
- data_ready (combinational) = rst_n && ((cnt != BITS_PER_SYM-1) || !sym_valid || sym_ready).
  - It deasserts only when the next bit would complete a symbol while the output register is full and not draining.
- Packing:
  - Accepted bit k (k = cnt) is placed at position BITS_PER_SYM-1-k when MSB_FIRST=1, or at position k when MSB_FIRST=0.
  - cnt increments per accepted bit and wraps from BITS_PER_SYM-1 to 0.
- Emission:
  - On the accept that fills position cnt=BITS_PER_SYM-1, sym_out is loaded with the complete symbol.
  - sym_valid=1 on the next cycle, so latency is 1 clk from the last bit.
  - sym_valid and sym_out are held stable until sym_valid && sym_ready.
  - Consume with no new completion: sym_valid=0 next cycle; sym_out keeps its last value.
  - Consume and completion in the same cycle: sym_out is loaded with the new symbol and sym_valid stays 1, giving full throughput with no bubble.
- sof:
  - An accepted bit with sof=1 is always treated as k=0.
  - If cnt != 0 at that time, the partial bits are discarded, sync_err=1 for exactly the next cycle, and cnt becomes 1.
  - sof with cnt==0 is a normal bit; no error.
  - sof on a non-accepted cycle is ignored.
  - For BITS_PER_SYM=2, an accepted sof bit at cnt==1 discards one bit and does not complete a symbol.
  - data_ready is still computed per the formula above, regardless of sof.
- sym_count:
  - Increments by 1 on each sym_valid && sym_ready and wraps 2^CNT_W-1 -> 0.
  - Registered; the update is visible the cycle after the consume.
- No other state exists. There is no FSM beyond cnt and the output-full flag.

Test Plan:
1. Bit order, MSB first: BITS_PER_SYM=2, MSB_FIRST=1, sym_ready=1, bits 1,0,1,1 on consecutive cycles -> sym_out=2'b10 one clk after bit 2 and 2'b11 one clk after bit 4; sym_valid high one cycle each; data_ready constant 1.
2. Bit order, LSB first: same stimulus with MSB_FIRST=0 -> sym_out=2'b01 then 2'b11.
3. Backpressure, BITS_PER_SYM=2, sym_ready=0:
   - Feed bits 1,0,0,1 -> 2'b10 is held with sym_valid=1.
   - Bit 3 is accepted; data_ready drops to 0 with cnt=1 and bit 4 is stalled.
   - Raise sym_ready for one cycle -> 2'b10 is consumed, bit 4 is accepted, next cycle sym_out=2'b01.
   - No bit is lost or duplicated; sym_count=1, then 2 after consuming 2'b01.
4. sof realignment, BITS_PER_SYM=4, MSB_FIRST=1: bits 1,1, then 0 with sof=1, then 1,0,1 -> sync_err pulses once (cycle after the sof bit); the only symbol out is 4'b0101.
5. Reset mid-symbol: BITS_PER_SYM=2, one bit (1) accepted, rst_n low for 2 cycles asynchronously between edges -> outputs 0 immediately and data_ready=0; after release, bits 0,1 -> sym_out=2'b01.
6. Counter wrap: CNT_W=4, BITS_PER_SYM=4, 17 symbols streamed with sym_ready=1 -> sym_count reads 15 after 15 symbols, 0 after 16, 1 after 17.
